// File: rtl/flow_capture_fifo.sv
// Capture stage for the secret-flow demo: queues non-zero out1/out2 words with source tag
// and shadow phase, drains them over valid/ready, and records every lost capture.
module flow_capture_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [DATA_W-1:0]          out1,
    input  logic [DATA_W-1:0]          out2,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_src,
    output logic [1:0]                 m_phase,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem_data  [DEPTH];
    logic              r_mem_src   [DEPTH];
    logic [1:0]        r_mem_phase [DEPTH];

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_phase;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_out1_nz;
    logic              w_out2_nz;
    logic              w_cand_valid;
    logic [DATA_W-1:0] w_cand_data;
    logic              w_cand_src;
    logic              w_pop;
    logic              w_push;
    logic              w_full_loss;
    logic [1:0]        w_losses;
    logic [CNT_W:0]    w_drop_sum;
    logic              w_valid;

    assign w_out1_nz    = (out1 != '0);
    assign w_out2_nz    = (out2 != '0);
    assign w_cand_valid = w_out1_nz | w_out2_nz;
    assign w_cand_src   = w_out2_nz;
    assign w_cand_data  = w_out2_nz ? out2 : out1;

    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid & m_ready;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign w_push       = w_cand_valid & ((r_count != FULL_COUNT) | w_pop);
    assign w_full_loss  = w_cand_valid & ~w_push;
    assign w_losses     = {1'b0, w_out1_nz & w_out2_nz} + {1'b0, w_full_loss};
    assign w_drop_sum   = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_losses);

    // Storage is deliberately left uninitialised; output gating hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_data[r_wr_ptr]  <= w_cand_data;
            r_mem_src[r_wr_ptr]   <= w_cand_src;
            r_mem_phase[r_wr_ptr] <= r_phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_phase    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (enable) begin
                r_phase <= r_phase + 2'd1;
            end
            if (w_full_loss) begin
                r_overflow <= 1'b1;
            end
            // At most two losses per cycle, so the carry bit alone signals saturation.
            r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
        end
    end

    assign m_valid  = w_valid;
    assign m_data   = w_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign m_src    = w_valid ? r_mem_src[r_rd_ptr]   : 1'b0;
    assign m_phase  = w_valid ? r_mem_phase[r_rd_ptr] : 2'd0;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_flow_capture_fifo.sv
// Randomised and directed bench for flow_capture_fifo, checked against a queue-based model.
module tb_flow_capture_fifo;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_src;
    logic [1:0]        m_phase;
    logic [2:0]        count;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;

    flow_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .out1(out1), .out2(out2),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_src(m_src),
        .m_phase(m_phase), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Model state: entry = {src, phase[1:0], data}
    logic [34:0] mq[$];
    int          m_phase_cnt = 0;
    bit          m_ovf = 0;
    int          m_drop = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit pop, push, cand;
        int losses;
        logic [34:0] e;
        if (rst) begin
            mq.delete();
            m_phase_cnt = 0;
            m_ovf = 0;
            m_drop = 0;
            return;
        end
        pop    = (mq.size() > 0) && m_ready;
        cand   = (out1 != 0) || (out2 != 0);
        losses = ((out1 != 0) && (out2 != 0)) ? 1 : 0;
        push   = 0;
        if (cand) begin
            if (mq.size() < DEPTH || pop) push = 1;
            else begin
                m_ovf = 1;
                losses++;
            end
        end
        e = (out2 != 0) ? {1'b1, 2'(m_phase_cnt), out2} : {1'b0, 2'(m_phase_cnt), out1};
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        m_drop = (m_drop + losses > CNT_MAX) ? CNT_MAX : m_drop + losses;
        if (enable) m_phase_cnt = (m_phase_cnt + 1) % 4;
    endtask

    task automatic check_all();
        logic [34:0] h;
        h = (mq.size() > 0) ? mq[0] : 35'd0;
        chk("m_valid", m_valid, mq.size() > 0);
        chk("m_data", m_data, h[31:0]);
        chk("m_src", m_src, h[34]);
        chk("m_phase", m_phase, h[33:32]);
        chk("count", count, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    // Inputs are set while at the negedge; this advances one clock and checks.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_all();
        $display("cycle %0d rst=%0b en=%0b o1=%0h o2=%0h rdy=%0b -> v=%0b d=%0h s=%0b ph=%0d cnt=%0d ovf=%0b drop=%0d",
                 cyc, rst, enable, out1, out2, m_ready, m_valid, m_data, m_src, m_phase, count, overflow, drop_cnt);
    endtask

    task automatic idle_in();
        rst = 0; enable = 0; out1 = 0; out2 = 0; m_ready = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        idle_in();
        @(negedge clk);

        // 1: single capture, first-word fall-through
        do_reset();
        chk("rst_valid", m_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_data", m_data, 0);
        enable = 1; out1 = 32'hAA;
        cycle();
        idle_in();
        chk("t1_valid", m_valid, 1);
        chk("t1_data", m_data, 32'hAA);
        chk("t1_src", m_src, 0);
        chk("t1_phase", m_phase, 0);
        chk("t1_count", count, 1);

        // 2: out2 wins, out1 lost
        do_reset();
        out1 = 32'h11; out2 = 32'h22;
        cycle();
        idle_in();
        chk("t2_data", m_data, 32'h22);
        chk("t2_src", m_src, 1);
        chk("t2_count", count, 1);
        chk("t2_drop", drop_cnt, 1);
        chk("t2_ovf", overflow, 0);

        // 3: overflow then drain
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            out1 = i;
            cycle();
        end
        idle_in();
        chk("t3_count", count, 4);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_cnt, 1);
        m_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain", m_data, i);
            cycle();
        end
        chk("t3_empty_valid", m_valid, 0);
        chk("t3_empty_data", m_data, 0);

        // 4: full with simultaneous pop and push
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            out1 = i;
            cycle();
        end
        out1 = 32'h77; m_ready = 1;
        cycle();
        idle_in();
        chk("t4_count", count, 4);
        chk("t4_ovf", overflow, 0);
        chk("t4_head", m_data, 2);

        // 5: phase recording and wrap
        do_reset();
        enable = 1;
        repeat (3) cycle();
        out2 = 32'hDEAD;
        cycle();
        idle_in();
        chk("t5_phase", m_phase, 3);
        chk("t5_data", m_data, 32'hDEAD);
        out1 = 5; m_ready = 1;
        cycle();
        idle_in();
        chk("t5_wrap_data", m_data, 5);
        chk("t5_wrap_phase", m_phase, 0);

        // 6: reset mid-operation
        do_reset();
        enable = 1;
        for (int i = 1; i <= 3; i++) begin
            out1 = 32'h30 + i;
            cycle();
        end
        idle_in();
        rst = 1; m_ready = 1;
        cycle();
        idle_in();
        chk("t6_count", count, 0);
        chk("t6_valid", m_valid, 0);
        chk("t6_data", m_data, 0);
        chk("t6_drop", drop_cnt, 0);
        out1 = 9;
        cycle();
        idle_in();
        chk("t6_phase", m_phase, 0);

        // drop counter saturation: each full cycle with both words non-zero loses 2
        do_reset();
        for (int i = 0; i < 140; i++) begin
            out1 = 32'h100 + i; out2 = 32'h200 + i;
            cycle();
        end
        idle_in();
        chk("sat_drop", drop_cnt, CNT_MAX);
        chk("sat_ovf", overflow, 1);

        // randomised traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            enable  = $urandom_range(0, 1);
            m_ready = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 1) : 1'b0;
            out1    = ($urandom_range(0, 2) == 0) ? $urandom : 32'd0;
            out2    = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
